// File: rtl/phase_timer.sv
// Multi-phase interval timer: steps through NUM_PHASES phases, each lasting a live-programmable
// number of cycles, with pause, restart and skip overrides. State advances on the falling edge.
module phase_timer #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned PHASE_W    = $clog2(NUM_PHASES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        restart,
    input  logic                        skip,
    input  logic [NUM_PHASES*WIDTH-1:0] durations,
    output logic [WIDTH-1:0]            cnt,
    output logic [PHASE_W-1:0]          phase,
    output logic [WIDTH-1:0]            remaining,
    output logic                        over_flag,
    output logic                        cycle_done
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [WIDTH-1:0]   dur;
    logic               at_terminal;

    // Duration of the current phase, sampled live so mid-phase edits take effect at once.
    always_comb begin
        dur = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase_q == PHASE_W'(i)) begin
                dur = durations[i*WIDTH +: WIDTH];
            end
        end
    end

    // >= rather than == so a duration cut below cnt still ends the phase instead of wrapping.
    assign at_terminal = (cnt_q >= dur);
    assign over_flag   = enable & ~restart & (at_terminal | skip);
    assign cycle_done  = over_flag & (phase_q == LAST_PHASE);
    assign remaining   = at_terminal ? '0 : (dur - cnt_q);
    assign cnt         = cnt_q;
    assign phase       = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (!enable) begin
            cnt_d   = cnt_q;
            phase_d = phase_q;
        end else if (over_flag) begin
            cnt_d   = '0;
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);
        end else begin
            cnt_d   = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule
